// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle for seg_scan_ctrl.
// The master drives the controls and the word; the slave drives the scan.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                  en;
  logic                  lz_en;
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic                  load_ack;
  logic [3:0]            hex_out;
  logic [DIGITS-1:0]     an;
  logic [IW-1:0]         digit_idx;

  modport master (
    output en, lz_en, load, data_in,
    input  load_ack, hex_out, an, digit_idx
  );

  modport slave (
    input  en, lz_en, load, data_in,
    output load_ack, hex_out, an, digit_idx
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan with guard gaps, frame-aligned
// word updates and optional leading-zero blanking.
module seg_scan_ctrl #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  seg_scan_ctrl_if.slave bus
);
  localparam int DW = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MX = (REFRESH_DIV > GUARD_CYCLES) ?
                      REFRESH_DIV : GUARD_CYCLES;
  localparam int CW = (MX > 1) ? $clog2(MX) : 1;

  localparam logic [CW-1:0] R_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [IW-1:0] D_LAST = IW'(DIGITS - 1);

  typedef enum logic {
    S_GUARD,
    S_DRIVE
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic [DW-1:0]   r_shadow;
  logic [DW-1:0]   r_disp;
  logic            r_pending;
  logic            r_load_ack;
  logic [3:0]      r_hex;

  logic            w_slot_end;
  logic            w_boundary;
  logic            w_apply;
  logic            w_sup;
  logic [DW-1:0]   w_disp_nx;
  logic [DW-1:0]   w_upper;
  logic [IW-1:0]   w_idx_nx;
  logic [DIGITS-1:0] w_an;

  assign w_slot_end = (r_state == S_DRIVE) && (r_cnt == R_LAST);
  assign w_boundary = bus.en && w_slot_end && (r_idx == D_LAST);

  // Ack gap keeps two pulses from abutting while the display is dark.
  assign w_apply = r_pending && !r_load_ack &&
                   (w_boundary || !bus.en);

  assign w_disp_nx = w_apply ? r_shadow : r_disp;
  assign w_idx_nx  = (r_idx == D_LAST) ? '0 : r_idx + 1'b1;
  assign w_upper   = r_disp >> {r_idx, 2'b00};
  assign w_sup     = bus.lz_en && (r_idx != '0) && (w_upper == '0);

  always_comb begin
    w_an = '1;
    if (bus.en && (r_state == S_DRIVE) && !w_sup)
      w_an[r_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_GUARD;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_disp     <= '0;
      r_pending  <= 1'b0;
      r_load_ack <= 1'b0;
      r_hex      <= '0;
    end else begin
      r_load_ack <= w_apply;
      if (w_apply) begin
        r_disp    <= r_shadow;
        r_pending <= 1'b0;
      end
      // A same-edge load lands after the apply, so it waits a frame.
      if (bus.load) begin
        r_shadow  <= bus.data_in;
        r_pending <= 1'b1;
      end
      if (!bus.en) begin
        r_state <= S_GUARD;
        r_cnt   <= '0;
        r_idx   <= '0;
        r_hex   <= w_disp_nx[3:0];
      end else begin
        unique case (r_state)
          S_GUARD: begin
            if (r_cnt == G_LAST) begin
              r_state <= S_DRIVE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_DRIVE: begin
            if (w_slot_end) begin
              r_state <= S_GUARD;
              r_cnt   <= '0;
              r_idx   <= w_idx_nx;
              r_hex   <= w_disp_nx[{w_idx_nx, 2'b00} +: 4];
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: begin
            r_state <= S_GUARD;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign bus.load_ack  = r_load_ack;
  assign bus.hex_out   = r_hex;
  assign bus.an        = w_an;
  assign bus.digit_idx = r_idx;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random traffic
// against a frame-position model of the scan.
module tb_seg_scan_ctrl;
  localparam int D    = 4;
  localparam int R    = 4;
  localparam int G    = 1;
  localparam int SLOT = G + R;
  localparam int F    = D * SLOT;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg_scan_ctrl_if #(.DIGITS(D)) bus ();

  seg_scan_ctrl #(
    .DIGITS      (D),
    .REFRESH_DIV (R),
    .GUARD_CYCLES(G)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int acks   = 0;
  int a0;

  // Model: position in the frame since the scan (re)started.
  int          m_t;
  logic [15:0] m_disp;
  logic [15:0] m_shadow;
  logic        m_pend;
  logic        m_ack;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_dig();
    return (m_t / SLOT) % D;
  endfunction

  function automatic bit m_sup(input int dg);
    if (!bus.lz_en || dg == 0) return 1'b0;
    for (int i = dg; i < D; i++)
      if (m_disp[4*i +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [D-1:0] m_an();
    logic [D-1:0] a;
    a = '1;
    if (bus.en && (m_t % SLOT) >= G && !m_sup(m_dig()))
      a[m_dig()] = 1'b0;
    return a;
  endfunction

  task automatic m_reset();
    m_t      = 0;
    m_disp   = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
    m_ack    = 1'b0;
  endtask

  task automatic m_edge();
    logic ap;
    ap = m_pend && !m_ack &&
         (!bus.en || ((m_t + 1) % F == 0));
    m_ack = ap;
    if (ap) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end
    if (bus.load) begin
      m_shadow = bus.data_in;
      m_pend   = 1'b1;
    end
    m_t = bus.en ? m_t + 1 : 0;
  endtask

  task automatic check_all();
    chk("an",  32'(bus.an),        32'(m_an()));
    chk("hex", 32'(bus.hex_out),   32'(m_disp[4*m_dig() +: 4]));
    chk("ack", 32'(bus.load_ack),  32'(m_ack));
    chk("idx", 32'(bus.digit_idx), 32'(m_dig()));
    if (bus.load_ack) acks++;
  endtask

  task automatic step(input logic ld, input logic [15:0] d);
    bus.load    = ld;
    bus.data_in = d;
    @(posedge clk);
    m_edge();
    #1;
    check_all();
    bus.load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0);
  endtask

  task automatic goto_pos(input int pos);
    for (int k = 0; k < F && (m_t % F) != pos; k++)
      step(1'b0, 16'h0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"},  32'(bus.an),        32'hF);
    chk({tag, "_hex"}, 32'(bus.hex_out),   32'h0);
    chk({tag, "_ack"}, 32'(bus.load_ack),  32'h0);
    chk({tag, "_idx"}, 32'(bus.digit_idx), 32'h0);
  endtask

  initial begin
    bus.en      = 1'b1;
    bus.lz_en   = 1'b0;
    bus.load    = 1'b0;
    bus.data_in = '0;
    m_reset();
    #2;
    chk_reset("rst0");
    #6 rst = 1'b0;

    // Idle scan with a blank word
    run(2 * F + 5);

    // Load in digit 1, shows from the next frame
    goto_pos(SLOT + G);
    step(1'b1, 16'h12AB);
    run(2 * F);

    // Two loads in one frame: one ack, last word wins
    goto_pos(2);
    a0 = acks;
    step(1'b1, 16'h1111);
    step(1'b0, 16'h0);
    step(1'b1, 16'h2222);
    run(F);
    chk("dbl_acks", 32'(acks - a0), 32'd1);

    // Leading-zero blanking on 0050
    goto_pos(2);
    step(1'b1, 16'h0050);
    run(F);
    bus.lz_en = 1'b1;
    run(2 * F);
    bus.lz_en = 1'b0;
    run(F);

    // Drop enable mid-drive with a word pending
    goto_pos(SLOT + G);
    step(1'b1, 16'h7777);
    bus.en = 1'b0;
    #1;
    chk("endrop_an", 32'(bus.an), 32'hF);
    a0 = acks;
    step(1'b0, 16'h0);
    chk("endrop_ack", 32'(acks - a0), 32'd1);
    run(3);
    bus.en = 1'b1;
    run(F + 3);

    // Async reset discards a pending word
    step(1'b1, 16'h9999);
    #1 rst = 1'b1;
    #1;
    chk_reset("arst");
    m_reset();
    #3 rst = 1'b0;
    a0 = acks;
    run(F + 5);
    chk("arst_noack", 32'(acks - a0), 32'd0);

    // Load on the boundary cycle while another word is pending
    goto_pos(2);
    step(1'b1, 16'hA5A5);
    goto_pos(F - 1);
    a0 = acks;
    step(1'b1, 16'h5A5A);
    chk("sim_ackA", 32'(acks - a0), 32'd1);
    run(F + 3);
    chk("sim_ackB", 32'(acks - a0), 32'd2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) bus.en = ~bus.en;
      if ($urandom_range(0, 29) == 0) bus.lz_en = ~bus.lz_en;
      step($urandom_range(0, 7) == 0,
           16'($urandom >> $urandom_range(0, 16)));
    end
    bus.en = 1'b1;
    run(F);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
